// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one block-RAM port between the VGA tile fetcher and the CPU,
// issuing one access per cycle and steering each read return back to its owner.
module vga_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LAT      = 1,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam int DEPTH  = MEM_LAT + 1;

    logic [WAIT_W-1:0] waitCnt;
    logic              starved, readGnt, retValid, retCpu;
    logic [DEPTH-1:0]  tagValid, tagCpu;

    always_comb begin
        starved  = waitCnt == WAIT_W'(CPU_MAX_WAIT);
        cpu_gnt  = !rst && cpu_req && (!vga_req || vblank || starved);
        vga_gnt  = !rst && vga_req && !cpu_gnt;
        readGnt  = vga_gnt || (cpu_gnt && !cpu_we);
        retValid = tagValid[DEPTH-1];
        retCpu   = tagCpu[DEPTH-1];
    end

    // tag[0] lines up with mem_addr; tag[DEPTH-1] lines up with the matching mem_rdata
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt    <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            tagValid   <= '0;
            tagCpu     <= '0;
            vga_rvalid <= 1'b0;
            vga_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            waitCnt    <= (!cpu_req || cpu_gnt) ? '0 : starved ? waitCnt : waitCnt + 1'b1;
            mem_addr   <= cpu_gnt ? cpu_addr : vga_gnt ? vga_addr : mem_addr;
            mem_wdata  <= cpu_gnt ? cpu_wdata : mem_wdata;
            mem_we     <= cpu_gnt && cpu_we;
            tagValid   <= {tagValid[DEPTH-2:0], readGnt};
            tagCpu     <= {tagCpu[DEPTH-2:0], cpu_gnt};
            vga_rvalid <= retValid && !retCpu;
            cpu_rvalid <= retValid && retCpu;
            vga_rdata  <= (retValid && !retCpu) ? mem_rdata : vga_rdata;
            cpu_rdata  <= (retValid && retCpu) ? mem_rdata : cpu_rdata;
        end
    end
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: randomized bench with a transaction-level reference model plus directed literal checks.
module tb_vga_mem_arbiter;
    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int MEM_LAT      = 1;
    localparam int CPU_MAX_WAIT = 8;

    logic              clk, rst, vblank;
    logic              vga_req, vga_gnt, vga_rvalid;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    vga_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .CPU_MAX_WAIT(CPU_MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .vblank(vblank),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: unwritten words hold addr+0x100; write-first, MEM_LAT cycles of read latency
    logic [DATA_W-1:0] ram [int];
    logic [DATA_W-1:0] rdPipe [MEM_LAT];
    assign mem_rdata = rdPipe[MEM_LAT-1];
    always @(posedge clk) begin
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
        rdPipe[0] <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : DATA_W'(mem_addr + 16'h100);
        for (int i = 1; i < MEM_LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // reference model: arbitration rules, a contents map and a queue of pending returns
    typedef struct {int due; bit cpu; logic [DATA_W-1:0] data;} ret_t;
    ret_t              pend [$];
    logic [DATA_W-1:0] mdl [int];
    int                cyc = 0;
    int                starve = 0;
    bit                armed = 0;
    bit                eV, eC, eVrv, eCrv, eWe;
    logic [DATA_W-1:0] eVrd, eCrd, eWdata;
    logic [ADDR_W-1:0] eAddr;

    function automatic logic [DATA_W-1:0] mdlRead(input logic [ADDR_W-1:0] a);
        return mdl.exists(int'(a)) ? mdl[int'(a)] : DATA_W'(a + 16'h100);
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            eVrv = 0;
            eCrv = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                if (pend[0].cpu) begin eCrv = 1; eCrd = pend[0].data; end
                else begin eVrv = 1; eVrd = pend[0].data; end
                void'(pend.pop_front());
            end
            chk("vga_rvalid", vga_rvalid, eVrv);
            chk("cpu_rvalid", cpu_rvalid, eCrv);
            chk("vga_rdata", vga_rdata, eVrd);
            chk("cpu_rdata", cpu_rdata, eCrd);
            chk("mem_we", mem_we, eWe);
            chk("mem_addr", mem_addr, eAddr);
            if (eWe) chk("mem_wdata", mem_wdata, eWdata);
        end
        eC = !rst && cpu_req && (!vga_req || vblank || starve >= CPU_MAX_WAIT);
        eV = !rst && vga_req && !eC;
        if (armed) begin
            chk("vga_gnt", vga_gnt, eV);
            chk("cpu_gnt", cpu_gnt, eC);
        end
        if (rst) begin
            starve = 0;
            pend.delete();
            eAddr = '0; eWe = 0; eWdata = '0; eVrd = '0; eCrd = '0;
            armed = 1;
        end else begin
            starve = (cpu_req && !eC) ? ((starve < CPU_MAX_WAIT) ? starve + 1 : starve) : 0;
            eWe = eC && cpu_we;
            if (eC) begin
                eAddr = cpu_addr;
                if (cpu_we) begin
                    eWdata = cpu_wdata;
                    mdl[int'(cpu_addr)] = cpu_wdata;
                end else pend.push_back('{cyc + 2 + MEM_LAT, 1'b1, mdlRead(cpu_addr)});
            end else if (eV) begin
                eAddr = vga_addr;
                pend.push_back('{cyc + 2 + MEM_LAT, 1'b0, mdlRead(vga_addr)});
            end
        end
        cyc++;
    end

    // per-cycle snapshot for the directed checks
    logic              sVgaGnt, sCpuGnt, sVgaRv, sCpuRv, sMemWe;
    logic [DATA_W-1:0] sVgaRd, sCpuRd, sMemWdata;
    logic [ADDR_W-1:0] sMemAddr;

    task automatic tick();
        @(negedge clk);
        sVgaGnt = vga_gnt; sCpuGnt = cpu_gnt;
        sVgaRv = vga_rvalid; sVgaRd = vga_rdata;
        sCpuRv = cpu_rvalid; sCpuRd = cpu_rdata;
        sMemWe = mem_we; sMemAddr = mem_addr; sMemWdata = mem_wdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; vblank = 0; vga_req = 0; vga_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) tick();
        rst = 0;
        // VGA streaming reads
        for (int i = 0; i < 6; i++) begin
            vga_req = 1; vga_addr = 16'(i + 1);
            tick();
            chk("t1_vga_gnt", sVgaGnt, 1);
            chk("t1_vga_rvalid", sVgaRv, i >= 3);
            if (i >= 3) chk("t1_vga_rdata", sVgaRd, 32'(16'h100 + i - 2));
        end
        vga_req = 0;
        repeat (4) tick();
        // CPU starvation bound in active video
        vga_req = 1; vga_addr = 16'h0080; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0090;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_vga_gnt", sVgaGnt, i != 8);
            chk("t2_cpu_gnt", sCpuGnt, i == 8);
        end
        vga_req = 0; cpu_req = 0;
        repeat (4) tick();
        // CPU priority in vblank
        vga_req = 1; cpu_req = 1; vblank = 1; cpu_addr = 16'h0060;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_cpu_gnt", sCpuGnt, 1);
            chk("t3_vga_gnt", sVgaGnt, 0);
        end
        vblank = 0;
        tick();
        chk("t3_vga_resume", sVgaGnt, 1);
        vga_req = 0; cpu_req = 0;
        repeat (6) tick();
        // write then read-back
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'h1234;
        tick();
        chk("t4_wr_gnt", sCpuGnt, 1);
        cpu_we = 0;
        tick();
        chk("t4_rd_gnt", sCpuGnt, 1);
        chk("t4_mem_we", sMemWe, 1);
        chk("t4_mem_addr", sMemAddr, 16'h0040);
        chk("t4_mem_wdata", sMemWdata, 16'h1234);
        cpu_req = 0;
        tick();
        chk("t4_rd_we", sMemWe, 0);
        tick();
        chk("t4_no_wr_rvalid", sCpuRv, 0);
        tick();
        chk("t4_rd_rvalid", sCpuRv, 1);
        chk("t4_rd_data", sCpuRd, 16'h1234);
        repeat (3) tick();
        // alternating owners
        for (int i = 0; i < 10; i++) begin
            vga_req = (i % 2 == 0); cpu_req = (i % 2 == 1); cpu_we = 0;
            vga_addr = 16'(16'h200 + i); cpu_addr = 16'(16'h300 + i);
            tick();
            chk("t5_vga_gnt", sVgaGnt, i % 2 == 0);
            chk("t5_cpu_gnt", sCpuGnt, i % 2 == 1);
            if (i >= 3) begin
                chk("t5_vga_rvalid", sVgaRv, (i - 3) % 2 == 0);
                chk("t5_cpu_rvalid", sCpuRv, (i - 3) % 2 == 1);
                if ((i - 3) % 2 == 0) chk("t5_vga_rdata", sVgaRd, 32'(16'h300 + i - 3));
                else chk("t5_cpu_rdata", sCpuRd, 32'(16'h400 + i - 3));
            end
        end
        vga_req = 0; cpu_req = 0;
        repeat (4) tick();
        // reset with two reads in flight
        vga_req = 1; vga_addr = 16'h0010;
        tick();
        vga_req = 0; cpu_req = 1; cpu_addr = 16'h0020;
        tick();
        cpu_req = 0; vga_req = 1; rst = 1;
        tick();
        chk("t6_rst_vga_gnt", sVgaGnt, 0);
        chk("t6_rst_cpu_gnt", sCpuGnt, 0);
        rst = 0; vga_req = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_vga_rvalid", sVgaRv, 0);
            chk("t6_cpu_rvalid", sCpuRv, 0);
            if (i == 0) begin
                chk("t6_mem_addr", sMemAddr, 0);
                chk("t6_mem_we", sMemWe, 0);
                chk("t6_vga_rdata", sVgaRd, 0);
                chk("t6_cpu_rdata", sCpuRd, 0);
            end
        end
        // randomized traffic: requests held until granted, occasional drops, vblank and reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 59) == 0) vblank = !vblank;
            if (vga_req) begin
                if ($urandom_range(0, 19) == 0) vga_req = 0;
            end else if ($urandom_range(0, 3) != 0) begin
                vga_req = 1; vga_addr = 16'($urandom_range(0, 31));
            end
            if (cpu_req) begin
                if ($urandom_range(0, 19) == 0) cpu_req = 0;
            end else if ($urandom_range(0, 2) != 0) begin
                cpu_req = 1; cpu_we = $urandom_range(0, 1) == 1;
                cpu_addr = 16'($urandom_range(0, 31)); cpu_wdata = 16'($urandom);
            end
            tick();
            if (sVgaGnt) vga_req = 0;
            if (sCpuGnt) cpu_req = 0;
        end
        rst = 0; vga_req = 0; cpu_req = 0;
        repeat (6) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
